// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl -- memory-side responder between the pipeline and a byte-wide
// synchronous RAM.
//
// Serves two requestors:
//   * IF port: 4-byte instruction fetches (level request if_read held until
//     if_ready). A fetch in flight is dropped if the fetch stage withdraws or
//     redirects it (branch).
//   * MEM port: 1/2/4-byte loads and stores (level requests held until
//     mem_ready; never withdrawn). MEM wins arbitration over IF.
// Each request becomes n consecutive byte accesses at base+k (modulo the RAM
// size). Read data is assembled little-endian and zero-extended.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   if_read/if_addr     fetch request and byte address
//   if_busy             controller is serving the MEM port
//   if_ready/if_data    one-cycle completion pulse, fetched word (held)
//   mem_read/mem_write  load / store request (mutually exclusive)
//   mem_addr/mem_len    byte address, size (00=1, 01=2, 1x=4 bytes)
//   mem_wdata           store data, byte k in bits [8k+7:8k]
//   mem_busy            controller is serving the IF port
//   mem_ready/mem_rdata one-cycle completion pulse, load data (held)
//   ram_a/ram_wr/ram_dout  RAM address, write enable, write data
//   ram_din             RAM read data, valid the cycle after ram_a
// ---------------------------------------------------------------------------
module mem_ctrl #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_read,
  input  logic [31:0]       if_addr,
  output logic              if_busy,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state;
  logic                owner_mem;   // 1: MEM port owns the transaction, 0: IF
  logic [RAM_AW-1:0]   base;
  logic [2:0]          n;           // transfer length in bytes (1, 2 or 4)
  logic [2:0]          ak;          // index of the next address to issue
  logic [2:0]          k;           // index of the next byte to capture
  logic [31:0]         asm_q;       // little-endian assembly register
  logic [31:0]         wdata_q;     // store data latched at acceptance

  // vld_pipe[0]: ram_a carries a freshly issued read address this cycle.
  // vld_pipe[1]: ram_din carries the byte for that address (one cycle later).
  logic [1:0]          vld_pipe;

  logic                mem_req;
  logic [2:0]          mem_n;
  logic                if_abort;
  logic                last_cap;
  logic [RAM_AW-1:0]   next_a;
  logic [7:0]          wbyte;
  logic [31:0]         asm_nxt;
  logic                unused_addr_bits;

  // Upper address bits are intentionally ignored (truncated addressing).
  assign unused_addr_bits = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

  assign mem_req = mem_read | mem_write;

  always_comb begin
    case (mem_len)
      2'b00:   mem_n = 3'd1;
      2'b01:   mem_n = 3'd2;
      default: mem_n = 3'd4;   // 10 is treated as a word
    endcase
  end

  // A fetch in flight is abandoned when the fetch stage drops or redirects
  // it; the replacement fetch is re-arbitrated from IDLE.
  assign if_abort = (state == READ) && !owner_mem &&
                    (!if_read || (if_addr[RAM_AW-1:0] != base));

  assign last_cap = vld_pipe[1] && (k == n - 3'd1);

  // Wrap-around past the top of RAM falls out of the RAM_AW-bit add.
  assign next_a = base + {{(RAM_AW-3){1'b0}}, ak};

  always_comb begin
    case (ak[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  // Assembly register with the byte arriving on ram_din merged in, so the
  // final byte can go straight to the data output on the completing edge.
  always_comb begin
    asm_nxt = asm_q;
    case (k[1:0])
      2'd0:    asm_nxt[7:0]   = ram_din;
      2'd1:    asm_nxt[15:8]  = ram_din;
      2'd2:    asm_nxt[23:16] = ram_din;
      default: asm_nxt[31:24] = ram_din;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner_mem <= 1'b0;
      base      <= '0;
      n         <= 3'd0;
      ak        <= 3'd0;
      k         <= 3'd0;
      asm_q     <= '0;
      wdata_q   <= '0;
      vld_pipe  <= '0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
      if_busy   <= 1'b0;
      mem_busy  <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            owner_mem <= 1'b1;
            base      <= mem_addr[RAM_AW-1:0];
            n         <= mem_n;
            ram_a     <= mem_addr[RAM_AW-1:0];
            ak        <= 3'd1;
            k         <= 3'd0;
            asm_q     <= '0;
            if_busy   <= 1'b1;
            mem_busy  <= 1'b0;
            if (mem_write) begin
              state    <= WRITE;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              wdata_q  <= mem_wdata;
              vld_pipe <= 2'b00;
            end else begin
              state    <= READ;
              vld_pipe <= 2'b01;
            end
          end else if (if_read) begin
            owner_mem <= 1'b0;
            base      <= if_addr[RAM_AW-1:0];
            n         <= 3'd4;
            ram_a     <= if_addr[RAM_AW-1:0];
            ak        <= 3'd1;
            k         <= 3'd0;
            asm_q     <= '0;
            mem_busy  <= 1'b1;
            if_busy   <= 1'b0;
            state     <= READ;
            vld_pipe  <= 2'b01;
          end
        end

        READ: begin
          if (if_abort) begin
            state    <= IDLE;
            vld_pipe <= 2'b00;
            if_busy  <= 1'b0;
            mem_busy <= 1'b0;
          end else begin
            vld_pipe <= {vld_pipe[0], (ak < n)};
            if (ak < n) begin
              ram_a <= next_a;
              ak    <= ak + 3'd1;
            end
            if (vld_pipe[1]) begin
              asm_q <= asm_nxt;
              k     <= k + 3'd1;
            end
            if (last_cap) begin
              state <= DONE;
              if (owner_mem) begin
                mem_ready <= 1'b1;
                mem_rdata <= asm_nxt;
              end else begin
                if_ready <= 1'b1;
                if_data  <= asm_nxt;
              end
            end
          end
        end

        WRITE: begin
          if (ak < n) begin
            ram_a    <= next_a;
            ram_dout <= wbyte;
            ak       <= ak + 3'd1;
          end else begin
            ram_wr    <= 1'b0;
            state     <= DONE;
            mem_ready <= 1'b1;
            mem_rdata <= asm_q;
          end
        end

        default: begin  // DONE: single completion cycle, no arbitration
          state    <= IDLE;
          k        <= 3'd0;
          vld_pipe <= 2'b00;
          if_busy  <= 1'b0;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-side responder for the pipeline's RAM request ports: accepts instruction-fetch reads from stage_if and load/store requests from the MEM stage, arbitrates between them, and sequences each request as 1, 2 or 4 byte accesses on the byte-wide synchronous RAM. It sits between the pipeline stages and the RAM. It returns a 32-bit little-endian result with a one-cycle ready pulse and signals busy to the port it is not serving.

## Interface
- RAM_AW, 17, width of the RAM byte address; request addresses are truncated to their low RAM_AW bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_read  input  1  fetch read request, level, held until if_ready.
- if_addr  input  32  fetch byte address. Fetches are always 4 bytes.
- if_busy  output  1  high while the controller is serving the MEM port.
- if_ready  output  1  one-cycle pulse: if_data is valid.
- if_data  output  32  fetched word.
- mem_read  input  1  load request, level.
- mem_write  input  1  store request, level. mem_read and mem_write are never both high.
- mem_addr  input  32  load/store byte address.
- mem_len  input  2  transfer size: 00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes; 10 is treated as 4 bytes.
- mem_wdata  input  32  store data. Byte k is mem_wdata[8k+7:8k].
- mem_busy  output  1  high while the controller is serving the IF port.
- mem_ready  output  1  one-cycle pulse: the load data is valid, or the store has completed.
- mem_rdata  output  32  load data, zero-extended. The MEM stage performs sign extension.
- ram_a  output  RAM_AW  RAM byte address.
- ram_wr  output  1  RAM write enable.
- ram_dout  output  8  RAM write data.
- ram_din  input  8  RAM read data. It is valid in the cycle after the address is on ram_a.

## Operation
- States: IDLE, READ, WRITE, DONE. The controller also holds the following registers: owner (IF or MEM), base address, length n, byte counter k, and a 32-bit assembly register.
- IDLE, arbitration:
  - A MEM request (mem_read or mem_write) wins over if_read.
  - For a MEM request: owner=MEM, n from mem_len, go to READ or WRITE.
  - For an IF-only request: owner=IF, n=4, go to READ.
  - With no request: stay in IDLE.
- READ:
  - ram_wr=0. ram_a = base+k for k = 0..n-1 on consecutive cycles.
  - Byte k is captured from ram_din one cycle later into assembly bits [8k+7:8k].
  - Unused upper bytes are 0.
  - After byte n-1 is captured, go to DONE.
- WRITE:
  - ram_wr=1, ram_a = base+k, ram_dout = byte k of mem_wdata, for k = 0..n-1 on consecutive cycles.
  - Then go to DONE.
- DONE:
  - Exactly one cycle. The owner's ready=1 and its data output carries the assembly register.
  - No new request is accepted in this cycle. Return to IDLE.
- The data outputs if_data and mem_rdata hold their value until the next completion of the same port.
- Address arithmetic is base+k modulo 2^RAM_AW. Wrap-around past the top of RAM is silent. No alignment is required.
- Abort applies only to an IF-owned READ. If if_read drops, or if_addr differs from the captured base, during READ:
  - Return to IDLE next cycle; no if_ready.
  - This covers branch redirect. The new fetch is re-arbitrated from IDLE.
- MEM requests are never withdrawn before mem_ready. There is no abort path for them.
- busy outputs:
  - if_busy = (state != IDLE) && owner == MEM.
  - mem_busy = (state != IDLE) && owner == IF.
  - Both are registered.
- In IDLE and DONE: ram_wr=0, and ram_a and ram_dout hold their last values.

## Timing
- Reset, asynchronous: state=IDLE, ram_a=0, ram_wr=0, ram_dout=0, if_ready=0, mem_ready=0, if_data=0, mem_rdata=0, if_busy=0, mem_busy=0, k=0.
- A reset asserted mid-transaction aborts it immediately. No ready is produced, and ram_wr falls asynchronously.
- Let cycle 0 be the cycle in which the request is high and the state is IDLE.
- Read of n bytes:
  - ram_a = base+k in cycle 1+k.
  - Byte k is sampled at the end of cycle 2+k.
  - ready is high in cycle n+2, i.e. cycle 6 for a word, cycle 3 for a byte.
- Write of n bytes:
  - ram_wr=1 in cycles 1..n.
  - mem_ready is high in cycle n+1 (cycle 5 for a word).
- Back-to-back: the requestor drops its request in the ready cycle. A pending request is accepted in the cycle after ready (the new cycle 0), so a word-fetch stream has a 7-cycle period.
- Simultaneous if_read and mem_read in IDLE: MEM is served first. if_busy rises in cycle 1, and the IF request is accepted in the cycle after mem_ready.

## Test plan
- Word fetch: RAM[0x100..0x103] = 13,05,00,00; if_read with if_addr=0x100.
  - if_ready in cycle 6, if_data=0x00000513.
  - ram_a = 0x100..0x103 in cycles 1..4; mem_busy=1 in cycles 1..6.
- Byte store then word load:
  - Store mem_wdata=0xAABBCCDD, mem_len=00 at 0x203: a single ram_wr cycle with ram_dout=0xDD, mem_ready in cycle 2.
  - Word load at 0x200 then returns 0xDD in bits [31:24], with the other bytes as preloaded.
- Half load at 0x1FFFF (RAM_AW=17): ram_a = 0x1FFFF then 0x00000. mem_rdata = {16'h0, RAM[0], RAM[0x1FFFF]}.
- Simultaneous if_read at 0x0 and word mem_read at 0x40:
  - mem_ready in cycle 6, with if_busy high in cycles 1..6.
  - IF accepted in cycle 7; if_ready in cycle 13.
- Fetch abort: if_addr changes from 0x100 to 0x200 in cycle 3.
  - No if_ready for 0x100; the controller is in IDLE in cycle 4.
  - 0x200 is accepted in cycle 4; if_ready in cycle 10 with the word at 0x200.
- Reset asserted in cycle 2 of a word write: ram_wr=0 immediately, all outputs at their reset values, no mem_ready; the next request is served normally.
